pl_stage_reg: RTL and testbench



---
 rtl/pl_stage_reg_pkg.sv | 24 ++
 rtl/pl_stage_reg_if.sv | 27 ++
 rtl/pl_stage_reg_sat_cnt.sv | 24 ++
 rtl/pl_stage_reg.sv | 130 +++++++++++++
 tb/tb_pl_stage_reg.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pl_stage_reg_pkg.sv
// Shared types and constants for the narrowwell pipeline stage registers.
// Holds the entry-state enum, default bundle widths and the per-stage control reset values.
package pl_pkg;

  typedef enum logic [1:0] {
    PL_EMPTY = 2'd0,
    PL_ONE   = 2'd1,
    PL_FULL  = 2'd2
  } pl_state_t;

  localparam int PL_CTRL_W = 16;
  localparam int PL_DATA_W = 128;

  // Control values a squashed slot must carry: everything deasserted (no write, no halt).
  localparam logic [PL_CTRL_W-1:0] PL_IFID_CTRL_RST  = '0;
  localparam logic [PL_CTRL_W-1:0] PL_IDEX_CTRL_RST  = '0;
  localparam logic [PL_CTRL_W-1:0] PL_EXMEM_CTRL_RST = '0;
  localparam logic [PL_CTRL_W-1:0] PL_MEMWB_CTRL_RST = '0;

  function automatic logic pl_has_room(input pl_state_t s);
    return s != PL_FULL;
  endfunction

endpackage

// File: rtl/pl_stage_reg_if.sv
// Valid/ready link through one pipeline stage: upstream (in_*) and downstream (out_*) sides.
// The stage register itself takes the slave modport; the surrounding pipeline takes master.
interface pl_stage_reg_if #(
  parameter int CTRL_W = pl_pkg::PL_CTRL_W,
  parameter int DATA_W = pl_pkg::PL_DATA_W
);

  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );

  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );

endinterface

// File: rtl/pl_stage_reg_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module pl_sat_cnt #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != {W{1'b1}})) begin
      cnt_reg <= cnt_reg + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/pl_stage_reg.sv
// Pipeline stage register: control + data bundle behind a valid/ready handshake,
// optional two-entry skid buffer, control-only flush and a saturating stall counter.
module pl_stage_reg
  import pl_pkg::*;
#(
  parameter int                CTRL_W   = PL_CTRL_W,
  parameter int                DATA_W   = PL_DATA_W,
  parameter logic [CTRL_W-1:0] CTRL_RST = '0,
  parameter int                SKID     = 1,
  parameter int                CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RST,
  pl_stage_reg_if.slave    bus,
  input  logic             flush,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  pl_state_t         state_reg, state_next;
  logic [CTRL_W-1:0] head_ctrl_reg, skid_ctrl;
  logic [DATA_W-1:0] head_data_reg, skid_data;
  logic              in_xfer, out_xfer;
  logic              load_head_in, load_head_skid, load_skid;

  assign in_xfer       = bus.in_valid && bus.in_ready;
  assign out_xfer      = bus.out_valid && bus.out_ready;
  assign bus.out_valid = (state_reg != PL_EMPTY);
  assign bus.out_ctrl  = head_ctrl_reg;
  assign bus.out_data  = head_data_reg;

  always_comb begin
    state_next     = state_reg;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state_reg)
      PL_EMPTY: begin
        if (in_xfer) begin
          state_next   = PL_ONE;
          load_head_in = 1'b1;
        end
      end
      PL_ONE: begin
        if (in_xfer && out_xfer) begin
          load_head_in = 1'b1;
        end else if (out_xfer) begin
          state_next = PL_EMPTY;
        end else if (in_xfer) begin
          state_next = PL_FULL;
          load_skid  = 1'b1;
        end
      end
      PL_FULL: begin
        if (out_xfer) begin
          state_next     = PL_ONE;
          load_head_skid = 1'b1;
        end
      end
      default: state_next = PL_EMPTY;
    endcase
    // A squash drops whatever was accepted or held this cycle.
    if (flush) begin
      state_next = PL_EMPTY;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= PL_EMPTY;
      head_ctrl_reg <= CTRL_RST;
      head_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (flush) begin
        head_ctrl_reg <= CTRL_RST;
      end else if (load_head_in) begin
        head_ctrl_reg <= bus.in_ctrl;
        head_data_reg <= bus.in_data;
      end else if (load_head_skid) begin
        head_ctrl_reg <= skid_ctrl;
        head_data_reg <= skid_data;
      end
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic [CTRL_W-1:0] skid_ctrl_reg;
      logic [DATA_W-1:0] skid_data_reg;
      logic              ready_reg;

      always_ff @(posedge CLK) begin
        if (RST) begin
          skid_ctrl_reg <= CTRL_RST;
          skid_data_reg <= '0;
          ready_reg     <= 1'b1;
        end else begin
          ready_reg <= pl_has_room(state_next);
          if (flush) begin
            skid_ctrl_reg <= CTRL_RST;
          end else if (load_skid) begin
            skid_ctrl_reg <= bus.in_ctrl;
            skid_data_reg <= bus.in_data;
          end
        end
      end

      assign skid_ctrl    = skid_ctrl_reg;
      assign skid_data    = skid_data_reg;
      // Registered ready keeps out_ready off the upstream timing path.
      assign bus.in_ready = ready_reg && !RST;
    end else begin : g_noskid
      assign skid_ctrl    = CTRL_RST;
      assign skid_data    = '0;
      assign bus.in_ready = (!bus.out_valid || bus.out_ready) && !RST;
    end
  endgenerate

  pl_sat_cnt #(
    .W (CNT_W)
  ) u_stall_cnt (
    .CLK (CLK),
    .RST (RST),
    .clr (clr_cnt),
    .inc (bus.out_valid && !bus.out_ready),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_pl_stage_reg.sv
// Bench for pl_stage_reg: SKID=1, SKID=0 and a 3-bit-counter instance share one stimulus;
// vector table plus hand sequences, with an in-order scoreboard on the two full-width instances.
module tb_pl_stage_reg;

  localparam logic [15:0] TB_CTRL_RST = 16'hC0DE;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_ctrl = '0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        flush = 1'b0;
  logic        clr_cnt = 1'b0;
  logic [15:0] st1, st0;
  logic [2:0]  st3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pl_stage_reg_if #(.CTRL_W(16), .DATA_W(32)) b1 ();
  pl_stage_reg_if #(.CTRL_W(16), .DATA_W(32)) b0 ();
  pl_stage_reg_if #(.CTRL_W(16), .DATA_W(32)) b3 ();

  assign b1.in_valid = in_valid;  assign b1.in_ctrl = in_ctrl;
  assign b1.in_data  = in_data;   assign b1.out_ready = out_ready;
  assign b0.in_valid = in_valid;  assign b0.in_ctrl = in_ctrl;
  assign b0.in_data  = in_data;   assign b0.out_ready = out_ready;
  assign b3.in_valid = in_valid;  assign b3.in_ctrl = in_ctrl;
  assign b3.in_data  = in_data;   assign b3.out_ready = out_ready;

  pl_stage_reg #(.CTRL_W(16), .DATA_W(32), .CTRL_RST(TB_CTRL_RST), .SKID(1), .CNT_W(16)) dut1 (
    .CLK(clk), .RST(rst), .bus(b1), .flush(flush), .clr_cnt(clr_cnt), .stall_cnt(st1));
  pl_stage_reg #(.CTRL_W(16), .DATA_W(32), .CTRL_RST(TB_CTRL_RST), .SKID(0), .CNT_W(16)) dut0 (
    .CLK(clk), .RST(rst), .bus(b0), .flush(flush), .clr_cnt(clr_cnt), .stall_cnt(st0));
  pl_stage_reg #(.CTRL_W(16), .DATA_W(32), .CTRL_RST(TB_CTRL_RST), .SKID(1), .CNT_W(3)) dut3 (
    .CLK(clk), .RST(rst), .bus(b3), .flush(flush), .clr_cnt(clr_cnt), .stall_cnt(st3));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // Drive one cycle's inputs just after the edge; return at the following negedge.
  task automatic cyc(input logic rs, input logic iv, input logic [15:0] c, input logic [31:0] d,
                     input logic ordy, input logic fl, input logic clr);
    @(posedge clk);
    #1;
    rst = rs; in_valid = iv; in_ctrl = c; in_data = d;
    out_ready = ordy; flush = fl; clr_cnt = clr;
    @(negedge clk);
  endtask

  // Scoreboards: accepted bundles queued in order, dropped on flush/reset.
  logic [47:0] q1[$];
  logic [47:0] q0[$];
  logic [47:0] exp1, exp0;

  always @(negedge clk) begin
    if (rst) begin
      q1.delete();
    end else begin
      if (b1.out_valid && out_ready) begin
        if (q1.size() == 0) begin
          check("sb1 unexpected output", {b1.out_ctrl, b1.out_data}, 64'hDEAD_0000_0000);
        end else begin
          exp1 = q1.pop_front();
          check("sb1 output", {b1.out_ctrl, b1.out_data}, exp1);
        end
      end
      if (flush) q1.delete();
      else if (in_valid && b1.in_ready) q1.push_back({in_ctrl, in_data});
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q0.delete();
    end else begin
      if (b0.out_valid && out_ready) begin
        if (q0.size() == 0) begin
          check("sb0 unexpected output", {b0.out_ctrl, b0.out_data}, 64'hDEAD_0000_0000);
        end else begin
          exp0 = q0.pop_front();
          check("sb0 output", {b0.out_ctrl, b0.out_data}, exp0);
        end
      end
      if (flush) q0.delete();
      else if (in_valid && b0.in_ready) q0.push_back({in_ctrl, in_data});
    end
  end

  typedef struct {
    logic        iv;
    logic [15:0] ic;
    logic [31:0] id;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [15:0] e_oc;
    logic [31:0] e_od;
    logic [15:0] e_st;
  } vec_t;

  function automatic vec_t mk(input logic iv, input logic [15:0] ic, input logic [31:0] id,
                              input logic ordy, input logic e_ir, input logic e_ov,
                              input logic [15:0] e_oc, input logic [31:0] e_od,
                              input logic [15:0] e_st);
    vec_t v;
    v.iv = iv; v.ic = ic; v.id = id; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_oc = e_oc; v.e_od = e_od; v.e_st = e_st;
    return v;
  endfunction

  vec_t vecs[12];

  initial begin
    // Expectations in row k reflect the edges driven by rows before k.
    vecs[0]  = mk(1, 16'h0001, 32'hA,   1, 1, 0, TB_CTRL_RST, 32'h0, 0);
    vecs[1]  = mk(1, 16'h0002, 32'hB,   1, 1, 1, 16'h0001, 32'hA,   0);
    vecs[2]  = mk(1, 16'h0003, 32'hC,   1, 1, 1, 16'h0002, 32'hB,   0);
    vecs[3]  = mk(1, 16'h0004, 32'hD,   1, 1, 1, 16'h0003, 32'hC,   0);
    vecs[4]  = mk(0, 16'h0000, 32'h0,   1, 1, 1, 16'h0004, 32'hD,   0);
    vecs[5]  = mk(0, 16'h0000, 32'h0,   0, 1, 0, 16'h0004, 32'hD,   0);
    vecs[6]  = mk(1, 16'h0011, 32'h111, 0, 1, 0, 16'h0004, 32'hD,   0);
    vecs[7]  = mk(1, 16'h0012, 32'h112, 0, 1, 1, 16'h0011, 32'h111, 0);
    vecs[8]  = mk(1, 16'h0013, 32'h113, 0, 0, 1, 16'h0011, 32'h111, 1);
    vecs[9]  = mk(0, 16'h0000, 32'h0,   1, 0, 1, 16'h0011, 32'h111, 2);
    vecs[10] = mk(0, 16'h0000, 32'h0,   1, 1, 1, 16'h0012, 32'h112, 2);
    vecs[11] = mk(0, 16'h0000, 32'h0,   1, 1, 0, 16'h0012, 32'h112, 2);

    // Reset
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    check("rst in_ready skid1", b1.in_ready, 0);
    check("rst in_ready skid0", b0.in_ready, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("post-rst out_valid", b1.out_valid, 0);
    check("post-rst out_ctrl", b1.out_ctrl, TB_CTRL_RST);
    check("post-rst out_data", b1.out_data, 0);
    check("post-rst stall_cnt", st1, 0);
    check("post-rst in_ready", b1.in_ready, 1);

    // Streaming and SKID=1 back-pressure
    for (int k = 0; k < 12; k++) begin
      cyc(0, vecs[k].iv, vecs[k].ic, vecs[k].id, vecs[k].ordy, 0, 0);
      check($sformatf("vec%0d in_ready", k), b1.in_ready, vecs[k].e_ir);
      check($sformatf("vec%0d out_valid", k), b1.out_valid, vecs[k].e_ov);
      check($sformatf("vec%0d out_ctrl", k), b1.out_ctrl, vecs[k].e_oc);
      check($sformatf("vec%0d out_data", k), b1.out_data, vecs[k].e_od);
      check($sformatf("vec%0d stall_cnt", k), st1, vecs[k].e_st);
    end

    // Flush while FULL, then flush discarding an accepted-looking input
    cyc(0, 1, 16'h00F1, 32'hF1F1, 0, 0, 0);
    cyc(0, 1, 16'h00F2, 32'hF2F2, 0, 0, 0);
    cyc(0, 1, 16'h00F3, 32'hF3F3, 0, 1, 0);
    check("full in_ready", b1.in_ready, 0);
    check("full head ctrl", b1.out_ctrl, 16'h00F1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("flush out_valid", b1.out_valid, 0);
    check("flush out_ctrl", b1.out_ctrl, TB_CTRL_RST);
    check("flush out_data held", b1.out_data, 32'hF1F1);
    check("flush in_ready", b1.in_ready, 1);
    cyc(0, 1, 16'h0055, 32'h5555, 0, 0, 0);
    cyc(0, 1, 16'h0066, 32'h6666, 0, 1, 0);
    check("one-state in_ready", b1.in_ready, 1);
    cyc(0, 0, 0, 0, 1, 0, 0);
    check("flush2 out_valid", b1.out_valid, 0);
    check("flush2 out_ctrl", b1.out_ctrl, TB_CTRL_RST);
    check("flush2 out_data held", b1.out_data, 32'h5555);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    check("flush2 nothing emerges", b1.out_valid, 0);

    // Stall counter: count, saturate, clear, flush interplay
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 16'h0021, 32'h2121, 0, 0, 0);
    repeat (6) cyc(0, 0, 0, 0, 0, 0, 0);
    check("stall 5 cnt16", st1, 5);
    check("stall 5 cnt3", st3, 5);
    repeat (5) cyc(0, 0, 0, 0, 0, 0, 0);
    check("stall 10 cnt16", st1, 10);
    check("stall 10 cnt3 saturated", st3, 7);
    check("stall hold out_ctrl", b1.out_ctrl, 16'h0021);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("clr beats inc cnt16", st1, 0);
    check("clr beats inc cnt3", st3, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    check("count resumes", st1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("flush keeps cnt", st1, 2);
    check("flush clears valid", b1.out_valid, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("no count when empty", st1, 2);
    cyc(0, 1, 16'h0022, 32'h2222, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("flush+clr cnt", st1, 0);
    check("flush+clr valid", b1.out_valid, 0);

    // SKID=0 (and SKID=1) full-rate streaming
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i <= 8; i++) begin
      cyc(0, (i < 8), 16'h0030 + 16'(i), 32'h3000 + 32'(i), 1, 0, 0);
      if (i >= 1) begin
        check($sformatf("s0 stream%0d valid", i), b0.out_valid, 1);
        check($sformatf("s0 stream%0d ctrl", i), b0.out_ctrl, 16'h0030 + 16'(i - 1));
        check($sformatf("s1 stream%0d ctrl", i), b1.out_ctrl, 16'h0030 + 16'(i - 1));
        check($sformatf("s0 stream%0d in_ready", i), b0.in_ready, 1);
      end
    end
    cyc(0, 1, 16'h0040, 32'h4040, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("s0 ready drops with out_ready", b0.in_ready, 0);
    check("s1 ready registered", b1.in_ready, 1);
    out_ready = 1'b1;
    #1;
    check("s0 ready follows out_ready", b0.in_ready, 1);

    // Reset while FULL
    cyc(0, 1, 16'h0071, 32'h7171, 0, 0, 0);
    cyc(0, 1, 16'h0072, 32'h7272, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("pre-rst full in_ready", b1.in_ready, 0);
    cyc(1, 1, 16'h0073, 32'h7373, 1, 0, 0);
    check("mid-rst in_ready forced", b1.in_ready, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    check("mid-rst out_valid", b1.out_valid, 0);
    check("mid-rst out_ctrl", b1.out_ctrl, TB_CTRL_RST);
    check("mid-rst out_data", b1.out_data, 0);
    check("mid-rst stall_cnt", st1, 0);
    check("mid-rst in_ready", b1.in_ready, 1);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    check("mid-rst nothing emerges", b1.out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
